regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass_pkg.sv | 10 +
 rtl/regfile_read_port.sv | 52 +++++
 rtl/regfile_bypass.sv | 114 +++++++++++
 tb/tb_regfile_bypass.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bypass_pkg.sv
// Shared constants for the bypassed register file and its read ports.
package regfile_bypass_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Value loaded into cleared entries and read registers.
  localparam logic [DEF_DATA_W-1:0] ZERO_DATA = '0;

endpackage : regfile_bypass_pkg

// File: rtl/regfile_read_port.sv
// One registered read port with write-first bypass.
// The returned value is the entry as it stands after the same edge's
// clear/writes. Priority: clear, then port 1 write, then port 0 write,
// then the stored entry.
module regfile_read_port
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] entries [2**ADDR_W],
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] rdata_next;

  // Select the post-edge value of the addressed entry.
  always_comb begin
    rdata_next = entries[raddr];
    if (clr) begin
      rdata_next = DATA_W'(ZERO_DATA);
    end else if (wr_en1 && (wr_addr1 == raddr)) begin
      rdata_next = wr_data1;
    end else if (wr_en0 && (wr_addr0 == raddr)) begin
      rdata_next = wr_data0;
    end
  end

  // Output register: loads on read enable, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_reg <= DATA_W'(ZERO_DATA);
    end else if (r_en) begin
      rdata_reg <= rdata_next;
    end
  end

  assign rdata = rdata_reg;

endmodule : regfile_read_port

// File: rtl/regfile_bypass.sv
// Two-write / two-read register file with write-first read bypass,
// flash clear, optional hardwired-zero entry 0 and a write-conflict flag.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en0,
  input  logic [ADDR_W-1:0] writeaddr0,
  input  logic [DATA_W-1:0] writedata0,
  input  logic              w_en1,
  input  logic [ADDR_W-1:0] writeaddr1,
  input  logic [DATA_W-1:0] writedata1,
  input  logic              r_en1,
  input  logic [ADDR_W-1:0] readaddr1,
  input  logic              r_en2,
  input  logic [ADDR_W-1:0] readaddr2,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic              wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] entry_reg [DEPTH];
  logic              we0_eff;
  logic              we1_eff;
  logic              conflict_next;
  logic              wr_conflict_reg;

  // Qualify writes: drop writes to a hardwired-zero entry 0, and drop
  // port 0 when port 1 targets the same address. A same-address pair
  // aimed at the hardwired entry is not a conflict.
  always_comb begin
    we1_eff       = w_en1 && !(ZERO_REG && (writeaddr1 == '0));
    we0_eff       = w_en0 && !(ZERO_REG && (writeaddr0 == '0));
    conflict_next = we0_eff && we1_eff && (writeaddr0 == writeaddr1);
    if (conflict_next) begin
      we0_eff = 1'b0;
    end
  end

  // Flip-flop storage, one register per entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam bit HARDWIRED = ZERO_REG && (gi == 0);
      // Entry update: reset/clear/hardwired zero, else port 1 over port 0.
      always_ff @(posedge clk) begin
        if (!rst || clr || HARDWIRED) begin
          entry_reg[gi] <= DATA_W'(ZERO_DATA);
        end else if (we1_eff && (writeaddr1 == ADDR_W'(gi))) begin
          entry_reg[gi] <= writedata1;
        end else if (we0_eff && (writeaddr0 == ADDR_W'(gi))) begin
          entry_reg[gi] <= writedata0;
        end
      end
    end
  endgenerate

  // Conflict flag reflects the previous edge's write pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_conflict_reg <= 1'b0;
    end else begin
      wr_conflict_reg <= conflict_next;
    end
  end

  assign wr_conflict = wr_conflict_reg;

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .r_en     (r_en1),
    .raddr    (readaddr1),
    .wr_en0   (we0_eff),
    .wr_addr0 (writeaddr0),
    .wr_data0 (writedata0),
    .wr_en1   (we1_eff),
    .wr_addr1 (writeaddr1),
    .wr_data1 (writedata1),
    .entries  (entry_reg),
    .rdata    (readdata1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .r_en     (r_en2),
    .raddr    (readaddr2),
    .wr_en0   (we0_eff),
    .wr_addr0 (writeaddr0),
    .wr_data0 (writedata0),
    .wr_en1   (we1_eff),
    .wr_addr1 (writeaddr1),
    .wr_data1 (writedata1),
    .entries  (entry_reg),
    .rdata    (readdata2)
  );

endmodule : regfile_bypass

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: a plain (ZERO_REG=0) and a hardwired-zero
// (ZERO_REG=1) instance share one stimulus stream and are checked every
// cycle against an array model, plus literal expectations.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        w_en0, w_en1, r_en1, r_en2;
  logic [3:0]  writeaddr0, writeaddr1, readaddr1, readaddr2;
  logic [15:0] writedata0, writedata1;

  logic [15:0] d_rd1 [2];
  logic [15:0] d_rd2 [2];
  logic        d_conf [2];

  logic [15:0] m_mem [2][16];
  logic [15:0] m_rd1 [2];
  logic [15:0] m_rd2 [2];
  logic        m_conf [2];

  int  total = 0;
  int  bad   = 0;
  bit  check_on = 1'b0;

  always #5 clk = ~clk;

  regfile_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .w_en0(w_en0), .writeaddr0(writeaddr0), .writedata0(writedata0),
    .w_en1(w_en1), .writeaddr1(writeaddr1), .writedata1(writedata1),
    .r_en1(r_en1), .readaddr1(readaddr1), .r_en2(r_en2), .readaddr2(readaddr2),
    .readdata1(d_rd1[0]), .readdata2(d_rd2[0]), .wr_conflict(d_conf[0])
  );

  regfile_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .clr(clr),
    .w_en0(w_en0), .writeaddr0(writeaddr0), .writedata0(writedata0),
    .w_en1(w_en1), .writeaddr1(writeaddr1), .writedata1(writedata1),
    .r_en1(r_en1), .readaddr1(readaddr1), .r_en2(r_en2), .readaddr2(readaddr2),
    .readdata1(d_rd1[1]), .readdata2(d_rd2[1]), .wr_conflict(d_conf[1])
  );

  // Model: apply the edge's writes to the array (port 0 first so port 1
  // overwrites it), then any read simply looks at the updated array.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int a = 0; a < 16; a++) m_mem[k][a] = 16'h0000;
        m_rd1[k]  = 16'h0000;
        m_rd2[k]  = 16'h0000;
        m_conf[k] = 1'b0;
      end else begin
        if (clr) begin
          for (int a = 0; a < 16; a++) m_mem[k][a] = 16'h0000;
        end else begin
          if (w_en0 && !(k == 1 && writeaddr0 == 4'd0)) m_mem[k][writeaddr0] = writedata0;
          if (w_en1 && !(k == 1 && writeaddr1 == 4'd0)) m_mem[k][writeaddr1] = writedata1;
        end
        m_conf[k] = w_en0 && w_en1 && (writeaddr0 == writeaddr1)
                    && !(k == 1 && writeaddr0 == 4'd0);
        if (r_en1) m_rd1[k] = m_mem[k][readaddr1];
        if (r_en2) m_rd2[k] = m_mem[k][readaddr2];
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_on) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d_rd1[k] !== m_rd1[k]) begin
          bad++;
          $display("FAIL cyc_rd1 inst=%0d got=%h want=%h t=%0t", k, d_rd1[k], m_rd1[k], $time);
        end
        total++;
        if (d_rd2[k] !== m_rd2[k]) begin
          bad++;
          $display("FAIL cyc_rd2 inst=%0d got=%h want=%h t=%0t", k, d_rd2[k], m_rd2[k], $time);
        end
        total++;
        if (d_conf[k] !== m_conf[k]) begin
          bad++;
          $display("FAIL cyc_conf inst=%0d got=%b want=%b t=%0t", k, d_conf[k], m_conf[k], $time);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end else begin
      $display("txn %s = %h ok", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; w_en0 = 0; w_en1 = 0; r_en1 = 0; r_en2 = 0;
  endtask

  initial begin
    rst = 0; idle();
    writeaddr0 = 0; writeaddr1 = 0; writedata0 = 0; writedata1 = 0;
    readaddr1 = 0; readaddr2 = 0;
    @(negedge clk);
    tick();
    check_on = 1'b1;
    tick();
    rst = 1;

    // Every address reads zero after reset.
    for (int a = 0; a < 16; a++) begin
      r_en1 = 1; r_en2 = 1; readaddr1 = 4'(a); readaddr2 = 4'(15 - a);
      tick();
      lit("reset_rd1", d_rd1[0], 16'h0000);
      lit("reset_rd2", d_rd2[0], 16'h0000);
      lit("reset_conf", {15'd0, d_conf[0]}, 16'h0000);
    end
    idle();

    // Basic write then read.
    w_en0 = 1; writeaddr0 = 4'd5; writedata0 = 16'hA5A5;
    tick();
    idle(); r_en1 = 1; readaddr1 = 4'd5;
    tick();
    lit("basic_rd1", d_rd1[0], 16'hA5A5);
    lit("model_basic", m_rd1[0], 16'hA5A5);

    // Same-edge port 1 write bypass.
    idle(); w_en1 = 1; writeaddr1 = 4'd3; writedata1 = 16'h1234; r_en2 = 1; readaddr2 = 4'd3;
    tick();
    lit("bypass1_rd2", d_rd2[0], 16'h1234);
    lit("model_bypass1", m_rd2[0], 16'h1234);

    // Conflict: port 1 wins, flag raised for one cycle.
    idle();
    w_en0 = 1; writeaddr0 = 4'd7; writedata0 = 16'h1111;
    w_en1 = 1; writeaddr1 = 4'd7; writedata1 = 16'h2222;
    r_en1 = 1; readaddr1 = 4'd7;
    tick();
    lit("conflict_rd1", d_rd1[0], 16'h2222);
    lit("conflict_flag", {15'd0, d_conf[0]}, 16'h0001);
    lit("model_conflict", {15'd0, m_conf[0]}, 16'h0001);
    idle(); r_en2 = 1; readaddr2 = 4'd7;
    tick();
    lit("conflict_stored", d_rd2[0], 16'h2222);
    lit("conflict_drop", {15'd0, d_conf[0]}, 16'h0000);

    // Same-edge port 0 write bypass.
    idle(); w_en0 = 1; writeaddr0 = 4'd9; writedata0 = 16'h5678; r_en1 = 1; readaddr1 = 4'd9;
    tick();
    lit("bypass0_rd1", d_rd1[0], 16'h5678);

    // Hold while address changes.
    idle(); readaddr1 = 4'd5;
    tick();
    lit("hold_rd1_a", d_rd1[0], 16'h5678);
    readaddr1 = 4'd3;
    tick();
    lit("hold_rd1_b", d_rd1[0], 16'h5678);

    // Flash clear beats a same-edge write and same-edge reads return zero.
    idle(); clr = 1; w_en0 = 1; writeaddr0 = 4'd2; writedata0 = 16'hFFFF;
    r_en1 = 1; readaddr1 = 4'd2; r_en2 = 1; readaddr2 = 4'd7;
    tick();
    lit("clr_same_rd1", d_rd1[0], 16'h0000);
    lit("clr_same_rd2", d_rd2[0], 16'h0000);
    idle();
    for (int a = 0; a < 16; a++) begin
      r_en1 = 1; r_en2 = 1; readaddr1 = 4'(a); readaddr2 = 4'(a);
      tick();
      lit("clr_after_rd1", d_rd1[0], 16'h0000);
    end
    idle();

    // Hardwired zero entry: single write then a same-address pair.
    w_en0 = 1; writeaddr0 = 4'd0; writedata0 = 16'hBEEF;
    tick();
    idle(); r_en1 = 1; readaddr1 = 4'd0;
    tick();
    lit("zr_rd1", d_rd1[1], 16'h0000);
    lit("zr_conf", {15'd0, d_conf[1]}, 16'h0000);
    lit("nz_rd1", d_rd1[0], 16'hBEEF);
    idle();
    w_en0 = 1; writeaddr0 = 4'd0; writedata0 = 16'hBEEF;
    w_en1 = 1; writeaddr1 = 4'd0; writedata1 = 16'hCAFE;
    r_en2 = 1; readaddr2 = 4'd0;
    tick();
    lit("zr_pair_conf", {15'd0, d_conf[1]}, 16'h0000);
    lit("nz_pair_conf", {15'd0, d_conf[0]}, 16'h0001);
    lit("zr_pair_rd2", d_rd2[1], 16'h0000);
    lit("nz_pair_rd2", d_rd2[0], 16'hCAFE);

    // Mid-stream reset discards the write and read on that edge.
    idle(); rst = 0; w_en0 = 1; writeaddr0 = 4'd4; writedata0 = 16'h4444;
    r_en1 = 1; readaddr1 = 4'd4;
    tick();
    lit("rst_mid_rd1", d_rd1[0], 16'h0000);
    lit("rst_mid_rd2", d_rd2[0], 16'h0000);
    rst = 1; idle(); r_en1 = 1; readaddr1 = 4'd4; r_en2 = 1; readaddr2 = 4'd0;
    tick();
    lit("rst_after_rd1", d_rd1[0], 16'h0000);
    lit("rst_after_rd2", d_rd2[0], 16'h0000);

    // Mixed traffic with narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) != 0);
      clr        = ($urandom_range(0, 29) == 0);
      w_en0      = 1'($urandom_range(0, 1));
      w_en1      = 1'($urandom_range(0, 1));
      r_en1      = 1'($urandom_range(0, 1));
      r_en2      = 1'($urandom_range(0, 1));
      writeaddr0 = 4'($urandom_range(0, 5));
      writeaddr1 = 4'($urandom_range(0, 5));
      readaddr1  = 4'($urandom_range(0, 5));
      readaddr2  = 4'($urandom_range(0, 5));
      writedata0 = 16'($urandom);
      writedata1 = 16'($urandom);
      tick();
    end
    rst = 1; idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_bypass
